alu_arbiter: RTL and testbench

//  Shares one combinational 16-bit ALU (ADD/AND/OR/XOR/SUB/NAND/NOR/XNOR, 3-bit control)

---
 rtl/alu_arbiter.sv | 97 +++++++++
 tb/tb_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two requesters.
// Optional `ALU_ARB_FLAGS_EN adds registered zero/negative result flags.
module alu_arbiter #(
    parameter int WIDTH  = 16,
    parameter int CTRL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*CTRL_W-1:0] req_ctrl,
    input  logic [2*WIDTH-1:0]  req_a,
    input  logic [2*WIDTH-1:0]  req_b,
    output logic [CTRL_W-1:0]   alu_ctrl,
    output logic [WIDTH-1:0]    alu_in0,
    output logic [WIDTH-1:0]    alu_in1,
    input  logic [WIDTH-1:0]    alu_dout,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
`ifdef ALU_ARB_FLAGS_EN
    output logic                rsp_zero,
    output logic                rsp_neg,
`endif
    output logic [1:0]          state_dbg
);

    // Handshakes: a request transfers on a rising edge where req_valid[i] && req_ready[i];
    // a response transfers on a rising edge where rsp_valid[i] && rsp_ready[i].
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   ptr;   // requester served most recently
    logic   gnt;   // requester owning the operation in flight
    logic   pick;

    always_comb begin
        pick = (req_valid == 2'b11) ? ~ptr : req_valid[1];
        req_ready = 2'b00;
        if (state == IDLE && !rst && req_valid != 2'b00)
            req_ready = pick ? 2'b10 : 2'b01;
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b1;
            gnt       <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
            alu_ctrl  <= '0;
            alu_in0   <= '0;
            alu_in1   <= '0;
`ifdef ALU_ARB_FLAGS_EN
            rsp_zero  <= 1'b0;
            rsp_neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        gnt      <= pick;
                        alu_ctrl <= pick ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
                        alu_in0  <= pick ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                        alu_in1  <= pick ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_dout;
`ifdef ALU_ARB_FLAGS_EN
                    rsp_zero  <= (alu_dout == '0);
                    rsp_neg   <= alu_dout[WIDTH-1];
`endif
                    rsp_valid <= gnt ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    // Only the owner's rsp_ready completes the operation.
                    if (rsp_ready[gnt]) begin
                        ptr       <= gnt;
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: stand-in ALU, constant vector table,
// hand-written reset/stall sequences and randomized traffic against a fairness model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_ctrl;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  alu_ctrl;
    logic [15:0] alu_in0;
    logic [15:0] alu_in1;
    logic [15:0] alu_dout;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  state_dbg;
`ifdef ALU_ARB_FLAGS_EN
    logic        rsp_zero;
    logic        rsp_neg;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int last_g;                  // model: requester served most recently
    logic [15:0] exp_q[$];

    typedef struct {
        logic [2:0]  ctrl;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    alu_arbiter #(.WIDTH(16), .CTRL_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b),
        .alu_ctrl(alu_ctrl), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_dout(alu_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef ALU_ARB_FLAGS_EN
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        case (c)
            3'd0: return a + b;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return a - b;
            3'd5: return ~(a & b);
            3'd6: return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction

    always_comb alu_dout = alu_ref(alu_ctrl, alu_in0, alu_in1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        req_ctrl[i*3 +: 3] = c;
        req_a[i*16 +: 16]  = a;
        req_b[i*16 +: 16]  = b;
        req_valid[i]       = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_g = 1;
        exp_q.delete();
    endtask

    // Called just after a negedge while the DUT is idle with req_valid already set.
    task automatic serve(input bit use_tab, input logic [15:0] tab_exp, input int stall);
        int g;
        logic [1:0]  own;
        logic [2:0]  c;
        logic [15:0] a, b, exp;
        g   = (req_valid == 2'b11) ? 1 - last_g : (req_valid[1] ? 1 : 0);
        own = (g == 1) ? 2'b10 : 2'b01;
        c = req_ctrl[g*3 +: 3];
        a = req_a[g*16 +: 16];
        b = req_b[g*16 +: 16];
        exp_q.push_back(use_tab ? tab_exp : alu_ref(c, a, b));
        #1 check("req_ready_grant", {30'd0, req_ready}, {30'd0, own});
        @(negedge clk);
        req_valid[g] = 1'b0;
        #1;
        check("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, c});
        check("alu_in0", {16'd0, alu_in0}, {16'd0, a});
        check("alu_in1", {16'd0, alu_in1}, {16'd0, b});
        check("exec_req_ready", {30'd0, req_ready}, 32'd0);
        check("exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        exp = exp_q.pop_front();
        check("rsp_valid", {30'd0, rsp_valid}, {30'd0, own});
        check("rsp_data", {16'd0, rsp_data}, {16'd0, exp});
`ifdef ALU_ARB_FLAGS_EN
        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, (exp == 16'd0)});
        check("rsp_neg", {31'd0, rsp_neg}, {31'd0, exp[15]});
`endif
        for (int s = 0; s < stall; s++) begin
            rsp_ready = 2'b00;
            rsp_ready[1-g] = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stall_rsp_valid", {30'd0, rsp_valid}, {30'd0, own});
            check("stall_rsp_data", {16'd0, rsp_data}, {16'd0, exp});
            check("stall_req_ready", {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = own;
        @(negedge clk);
        rsp_ready = 2'b00;
        last_g = g;
        check("done_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tab[9];
        tab[0] = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000};
        tab[1] = '{3'd0, 16'hA5A5, 16'h0F0F, 16'hB4B4};
        tab[2] = '{3'd1, 16'hA5A5, 16'h0F0F, 16'h0505};
        tab[3] = '{3'd2, 16'hA5A5, 16'h0F0F, 16'hAFAF};
        tab[4] = '{3'd3, 16'hA5A5, 16'h0F0F, 16'hAAAA};
        tab[5] = '{3'd4, 16'hA5A5, 16'h0F0F, 16'h9696};
        tab[6] = '{3'd5, 16'hA5A5, 16'h0F0F, 16'hFAFA};
        tab[7] = '{3'd6, 16'hA5A5, 16'h0F0F, 16'h5050};
        tab[8] = '{3'd7, 16'hA5A5, 16'h0F0F, 16'h5555};

        req_ctrl = '0; req_a = '0; req_b = '0;
        do_reset();
        #1;
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("rst_alu", {13'd0, alu_ctrl, alu_in0 | alu_in1}, 32'd0);
        @(negedge clk);

        // Single requester, overflow wraps without carry.
        set_req(0, tab[0].ctrl, tab[0].a, tab[0].b);
        serve(1'b1, tab[0].exp, 0);

        // All eight functions through requester 1.
        for (int i = 1; i < 9; i++) begin
            set_req(1, tab[i].ctrl, tab[i].a, tab[i].b);
            serve(1'b1, tab[i].exp, 0);
        end

        // Tie after reset: r0 first, then r1, then alternation while both stay valid.
        do_reset();
        set_req(0, 3'd4, 16'd5, 16'd7);
        set_req(1, 3'd7, 16'hFFFF, 16'h00FF);
        serve(1'b1, 16'hFFFE, 0);
        req_valid[0] = 1'b1;
        serve(1'b1, 16'h00FF, 0);
        for (int k = 0; k < 8; k++) begin
            req_valid = 2'b11;
            serve(1'b0, 16'h0, 0);
        end

        // Long stall with the peer waiting.
        req_valid = 2'b11;
        serve(1'b0, 16'h0, 5);
        req_valid = 2'b00;
        @(negedge clk);

        // Reset during RESP aborts the operation silently.
        set_req(0, 3'd0, 16'h1234, 16'h1111);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        check("pre_rst_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_resp_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_resp_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("rst_resp_state", {30'd0, state_dbg}, 32'd0);

        // Reset during EXEC.
        set_req(1, 3'd2, 16'h0F00, 16'h00F0);
        @(negedge clk);
        check("pre_rst_state", {30'd0, state_dbg}, 32'd1);
        rst = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        last_g = 1;
        #1;
        check("rst_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_exec_state", {30'd0, state_dbg}, 32'd0);
        check("rst_exec_alu_in0", {16'd0, alu_in0}, 32'd0);
        @(negedge clk);
        set_req(0, 3'd4, 16'h0000, 16'h0000);
        set_req(1, 3'd0, 16'h0001, 16'h0001);
        serve(1'b1, 16'h0000, 0);
        req_valid = 2'b00;
        serve_pending_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Random traffic: each idle requester may raise a new op; waiting ops are held.
    task automatic serve_pending_random();
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
            if (req_valid == 2'b00)
                set_req($urandom_range(0, 1), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
            serve(1'b0, 16'h0, $urandom_range(0, 3));
        end
    endtask

endmodule
